ghost_motion: RTL and testbench



---
 rtl/ghost_pkg.sv | 25 ++
 rtl/ghost_step.sv | 32 +++
 rtl/ghost_motion.sv | 145 ++++++++++++++
 tb/tb_ghost_motion.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared ghost definitions: direction codes, life-cycle states, position widths.
package ghost_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] RIGHT    = 4'b0001;
  localparam logic [3:0] UP       = 4'b0010;
  localparam logic [3:0] DOWN     = 4'b0100;
  localparam logic [3:0] LEFT     = 4'b1000;

  typedef enum logic [1:0] {
    GS_HOME    = 2'd0,
    GS_EXIT    = 2'd1,
    GS_ROAM    = 2'd2,
    GS_RESPAWN = 2'd3
  } ghost_state_t;

  // True when exactly one direction bit is set.
  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/ghost_step.sv
// One-step position update for a one-hot direction, with horizontal wrap.
module ghost_step
  import ghost_pkg::*;
#(
  parameter int STEP     = 1,
  parameter int SCREEN_W = 640
) (
  input  logic [X_W-1:0] pos_x,
  input  logic [Y_W-1:0] pos_y,
  input  logic [3:0]     dir,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y
);

  localparam logic [X_W-1:0] STEP_X = X_W'(STEP);
  localparam logic [Y_W-1:0] STEP_Y = Y_W'(STEP);
  localparam logic [X_W-1:0] LAST_X = X_W'(SCREEN_W - STEP);

  // Apply one step; x wraps at the screen edges, y never wraps.
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    case (dir)
      RIGHT: next_x = (pos_x == LAST_X) ? '0 : pos_x + STEP_X;
      LEFT:  next_x = (pos_x == '0) ? LAST_X : pos_x - STEP_X;
      UP:    next_y = pos_y - STEP_Y;
      DOWN:  next_y = pos_y + STEP_Y;
      default: ;
    endcase
  end

endmodule

// File: rtl/ghost_motion.sv
// Ghost position and life-cycle controller driven by the steering interface.
module ghost_motion
  import ghost_pkg::*;
#(
  parameter int START_X       = 320,
  parameter int START_Y       = 240,
  parameter int EXIT_Y        = 208,
  parameter int TILE_LOG2     = 4,
  parameter int STEP          = 1,
  parameter int SCREEN_W      = 640,
  parameter int RELEASE_TICKS = 120,
  parameter int RESPAWN_TICKS = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           move_tick,
  input  logic [3:0]     move_direction,
  input  logic [3:0]     valid_moves,
  input  logic           caught,
  output logic [X_W-1:0] ghost_pos_x,
  output logic [Y_W-1:0] ghost_pos_y,
  output logic [3:0]     prev_direction,
  output logic [1:0]     ghost_state,
  output logic           stalled
);

  localparam int CNT_MAX = (RELEASE_TICKS > RESPAWN_TICKS) ? RELEASE_TICKS : RESPAWN_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [X_W-1:0]   HOME_X      = X_W'(START_X);
  localparam logic [Y_W-1:0]   HOME_Y      = Y_W'(START_Y);
  localparam logic [Y_W-1:0]   EXIT_Y_V    = Y_W'(EXIT_Y);
  localparam logic [CNT_W-1:0] RELEASE_END = CNT_W'(RELEASE_TICKS - 1);
  localparam logic [CNT_W-1:0] RESPAWN_END = CNT_W'(RESPAWN_TICKS - 1);

  ghost_state_t     state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [X_W-1:0]   x_nxt, step_x;
  logic [Y_W-1:0]   y_nxt, step_y;
  logic [3:0]       prev_nxt, step_dir;
  logic             stalled_nxt;
  logic             aligned, req_ok, prev_ok;

  assign aligned = (ghost_pos_x[TILE_LOG2-1:0] == '0) && (ghost_pos_y[TILE_LOG2-1:0] == '0);
  assign req_ok  = aligned && is_onehot4(move_direction) && ((move_direction & valid_moves) != 4'b0000);
  assign prev_ok = (prev_direction != DIR_NONE) &&
                   (!aligned || ((prev_direction & valid_moves) != 4'b0000));

  // Direction actually taken this tick: forced UP while exiting, steering choice while roaming.
  always_comb begin
    step_dir = DIR_NONE;
    case (state_q)
      GS_EXIT: step_dir = UP;
      GS_ROAM: begin
        if (req_ok)       step_dir = move_direction;
        else if (prev_ok) step_dir = prev_direction;
      end
      default: ;
    endcase
  end

  ghost_step #(
    .STEP     (STEP),
    .SCREEN_W (SCREEN_W)
  ) u_step (
    .pos_x  (ghost_pos_x),
    .pos_y  (ghost_pos_y),
    .dir    (step_dir),
    .next_x (step_x),
    .next_y (step_y)
  );

  // Life-cycle transitions and position updates; caught pre-empts any tick.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    x_nxt       = ghost_pos_x;
    y_nxt       = ghost_pos_y;
    prev_nxt    = prev_direction;
    stalled_nxt = 1'b0;
    if (caught && (state_q != GS_RESPAWN)) begin
      state_nxt = GS_RESPAWN;
      cnt_nxt   = '0;
      x_nxt     = HOME_X;
      y_nxt     = HOME_Y;
      prev_nxt  = DIR_NONE;
    end else if (move_tick) begin
      case (state_q)
        GS_HOME: begin
          if (cnt_q == RELEASE_END) begin
            state_nxt = GS_EXIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        GS_EXIT: begin
          y_nxt    = step_y;
          prev_nxt = UP;
          if (step_y == EXIT_Y_V) state_nxt = GS_ROAM;
        end
        GS_ROAM: begin
          if (step_dir != DIR_NONE) begin
            x_nxt    = step_x;
            y_nxt    = step_y;
            prev_nxt = step_dir;
          end else begin
            stalled_nxt = 1'b1;
          end
        end
        GS_RESPAWN: begin
          if (cnt_q == RESPAWN_END) begin
            state_nxt = GS_HOME;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; asynchronous reset restores the house start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GS_HOME;
      cnt_q          <= '0;
      ghost_pos_x    <= HOME_X;
      ghost_pos_y    <= HOME_Y;
      prev_direction <= DIR_NONE;
      stalled        <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      cnt_q          <= cnt_nxt;
      ghost_pos_x    <= x_nxt;
      ghost_pos_y    <= y_nxt;
      prev_direction <= prev_nxt;
      stalled        <= stalled_nxt;
    end
  end

  assign ghost_state = state_q;

endmodule

// File: tb/tb_ghost_motion.sv
// Directed bench for ghost_motion: house release, exit, roaming, wrap, capture, reset.
module tb_ghost_motion;

  logic        clk;
  logic        rst_n;
  logic        move_tick;
  logic [3:0]  move_direction;
  logic [3:0]  valid_moves;
  logic        caught;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  prev_direction;
  logic [1:0]  ghost_state;
  logic        stalled;

  int n_cmp = 0;
  int n_err = 0;

  ghost_motion dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .move_tick      (move_tick),
    .move_direction (move_direction),
    .valid_moves    (valid_moves),
    .caught         (caught),
    .ghost_pos_x    (ghost_pos_x),
    .ghost_pos_y    (ghost_pos_y),
    .prev_direction (prev_direction),
    .ghost_state    (ghost_state),
    .stalled        (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick pulse; returns at the next negedge, after the update edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
    end
  endtask

  task automatic steer(input logic [3:0] md, input logic [3:0] vm);
    move_direction = md;
    valid_moves    = vm;
  endtask

  initial begin
    rst_n = 1'b0; move_tick = 1'b0; caught = 1'b0;
    move_direction = 4'b0000; valid_moves = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(ghost_pos_x), 320);
    chk("rst_y", 32'(ghost_pos_y), 240);
    chk("rst_prev", 32'(prev_direction), 0);
    chk("rst_state", 32'(ghost_state), 0);
    chk("rst_stalled", 32'(stalled), 0);
    rst_n = 1'b1;

    // House: inputs must be ignored
    steer(4'b0001, 4'b1111);
    tick(119);
    chk("home_119", 32'(ghost_state), 0);
    chk("home_y", 32'(ghost_pos_y), 240);
    tick(1);
    chk("exit_enter", 32'(ghost_state), 1);
    chk("exit_enter_y", 32'(ghost_pos_y), 240);
    tick(1);
    chk("exit_y239", 32'(ghost_pos_y), 239);
    chk("exit_prev", 32'(prev_direction), 4'b0010);
    chk("exit_x", 32'(ghost_pos_x), 320);
    tick(30);
    chk("exit_y209", 32'(ghost_pos_y), 209);
    chk("exit_still", 32'(ghost_state), 1);
    tick(1);
    chk("roam_y", 32'(ghost_pos_y), 208);
    chk("roam_state", 32'(ghost_state), 2);
    chk("roam_prev", 32'(prev_direction), 4'b0010);

    // Turn at aligned tile, then no turn between tiles
    steer(4'b0001, 4'b1001);
    tick(1);
    chk("turn_x", 32'(ghost_pos_x), 321);
    chk("turn_prev", 32'(prev_direction), 4'b0001);
    steer(4'b0010, 4'b1111);
    tick(1);
    chk("noturn_x", 32'(ghost_pos_x), 322);
    chk("noturn_y", 32'(ghost_pos_y), 208);
    chk("noturn_prev", 32'(prev_direction), 4'b0001);
    tick(14);
    chk("to336", 32'(ghost_pos_x), 336);

    // Blocked request and blocked momentum
    steer(4'b0010, 4'b1000);
    tick(1);
    chk("stall_pulse", 32'(stalled), 1);
    chk("stall_x", 32'(ghost_pos_x), 336);
    chk("stall_y", 32'(ghost_pos_y), 208);
    chk("stall_prev", 32'(prev_direction), 4'b0001);
    @(negedge clk);
    chk("stall_drop", 32'(stalled), 0);

    // Left to x=0, then wrap
    steer(4'b1000, 4'b1000);
    tick(336);
    chk("left_x0", 32'(ghost_pos_x), 0);
    tick(1);
    chk("wrap_left", 32'(ghost_pos_x), 639);
    chk("wrap_left_prev", 32'(prev_direction), 4'b1000);
    tick(15);
    chk("left_624", 32'(ghost_pos_x), 624);
    steer(4'b0001, 4'b0001);
    tick(15);
    chk("right_639", 32'(ghost_pos_x), 639);
    tick(1);
    chk("wrap_right", 32'(ghost_pos_x), 0);
    chk("wrap_right_prev", 32'(prev_direction), 4'b0001);

    // Navigate to (400,176)
    tick(400);
    chk("nav_x", 32'(ghost_pos_x), 400);
    steer(4'b0010, 4'b0010);
    tick(32);
    chk("nav_y", 32'(ghost_pos_y), 176);
    chk("nav_prev", 32'(prev_direction), 4'b0010);

    // Multi-hot request is no request; momentum blocked
    steer(4'b0011, 4'b0001);
    tick(1);
    chk("multihot_stall", 32'(stalled), 1);
    chk("multihot_x", 32'(ghost_pos_x), 400);
    chk("multihot_y", 32'(ghost_pos_y), 176);

    // Capture coincident with a tick
    steer(4'b0001, 4'b1111);
    @(negedge clk) begin caught = 1'b1; move_tick = 1'b1; end
    @(negedge clk) begin caught = 1'b0; move_tick = 1'b0; end
    chk("caught_x", 32'(ghost_pos_x), 320);
    chk("caught_y", 32'(ghost_pos_y), 240);
    chk("caught_prev", 32'(prev_direction), 0);
    chk("caught_state", 32'(ghost_state), 3);
    chk("caught_stalled", 32'(stalled), 0);

    // Capture ignored while respawning
    tick(10);
    @(negedge clk) caught = 1'b1;
    @(negedge clk) caught = 1'b0;
    chk("resp_ignore", 32'(ghost_state), 3);
    tick(49);
    chk("resp_59", 32'(ghost_state), 3);
    tick(1);
    chk("resp_home", 32'(ghost_state), 0);
    chk("resp_home_x", 32'(ghost_pos_x), 320);

    // Back into EXIT, then asynchronous reset between edges
    tick(120);
    tick(5);
    chk("exit2_y", 32'(ghost_pos_y), 235);
    chk("exit2_state", 32'(ghost_state), 1);
    chk("exit2_stalled", 32'(stalled), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", 32'(ghost_pos_x), 320);
    chk("arst_y", 32'(ghost_pos_y), 240);
    chk("arst_state", 32'(ghost_state), 0);
    chk("arst_prev", 32'(prev_direction), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(119);
    chk("post_rst_home", 32'(ghost_state), 0);
    tick(1);
    chk("post_rst_exit", 32'(ghost_state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
